// File: rtl/exception_unit_if.sv
// Bus between the multicycle MIPS controller/datapath and the exception sequencer:
// exception causes, RFE, PC, vector-memory read port and the PC-source target.
interface exception_unit_if;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic        rfe;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] exc_target;
    logic        pc_load;
    logic [31:0] epc_out;
    logic [1:0]  cause_out;
    logic        exc_busy;

    // Datapath/controller side: raises exceptions, serves memory, consumes the target.
    modport master (
        output exc_opcode, exc_overflow, exc_div0, rfe, pc_in, mem_data_in,
        input  mem_read, mem_addr, exc_target, pc_load, epc_out, cause_out, exc_busy
    );

    // Sequencer side.
    modport slave (
        input  exc_opcode, exc_overflow, exc_div0, rfe, pc_in, mem_data_in,
        output mem_read, mem_addr, exc_target, pc_load, epc_out, cause_out, exc_busy
    );
endinterface

// File: rtl/exception_unit.sv
// Exception-entry / return-from-exception sequencer feeding PC-source mux input 2'b11.
// Optional: define EXC_COUNT_EN to add an 8-bit saturating count of accepted exceptions (exc_count).
module exception_unit #(
    parameter logic [31:0] VEC_BASE    = 32'd253,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
`ifdef EXC_COUNT_EN
    output logic [7:0]       exc_count,
`endif
    exception_unit_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] RET  = 2'd3;

    localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
    localparam logic [1:0] CAUSE_DIV0     = 2'd2;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  wait_cnt;
    logic [31:0] handler;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] target_hold;
    logic        any_exc;
    logic        read_done;
    logic [1:0]  cause_sel;
    logic        unused_mem_hi;

    assign any_exc   = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
    assign read_done = (wait_cnt == LAT_LAST);

    // Only the low byte of a vector entry is meaningful; the handler lives in the first 256 bytes.
    assign unused_mem_hi = ^bus.mem_data_in[31:8];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cause_sel = CAUSE_DIV0;
        if (bus.exc_opcode)        cause_sel = CAUSE_OPCODE;
        else if (bus.exc_overflow) cause_sel = CAUSE_OVERFLOW;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_exc)      state_nxt = READ;
                else if (bus.rfe) state_nxt = RET;
            end
            READ:    if (read_done) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            RET:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            handler     <= 32'd0;
            epc         <= 32'd0;
            cause       <= 2'd0;
            target_hold <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_exc) begin
                        cause    <= cause_sel;
                        epc      <= bus.pc_in - 32'd4;
                        wait_cnt <= 4'd0;
                    end
                end
                READ: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (read_done) handler <= {24'd0, bus.mem_data_in[7:0]};
                end
                LOAD:    target_hold <= handler;
                RET:     target_hold <= epc;
                default: ;
            endcase
        end
    end

`ifdef EXC_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            exc_count <= 8'd0;
        else if (state == IDLE && any_exc && exc_count != 8'hFF)
            exc_count <= exc_count + 8'd1;
    end
`endif

    // Outputs are decoded from state and registers only; inputs never reach them combinationally.
    always_comb begin
        bus.mem_read   = (state == READ);
        bus.mem_addr   = (state == READ) ? VEC_BASE + {30'd0, cause} : 32'd0;
        bus.pc_load    = (state == LOAD) || (state == RET);
        bus.exc_busy   = (state != IDLE);
        bus.epc_out    = epc;
        bus.cause_out  = cause;
        bus.exc_target = target_hold;
        if (state == LOAD)     bus.exc_target = handler;
        else if (state == RET) bus.exc_target = epc;
    end

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit (MEM_LATENCY = 2, VEC_BASE = 253).
module tb_exception_unit;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
`ifdef EXC_COUNT_EN
    logic [7:0] exc_count;
`endif

    exception_unit_if bus ();

    exception_unit #(.VEC_BASE(32'd253), .MEM_LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef EXC_COUNT_EN
        .exc_count(exc_count),
`endif
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Vector memory; upper bytes carry junk that must be masked off.
    always_comb begin
        case (bus.mem_addr)
            32'd253: bus.mem_data_in = 32'hAAAA_AA20;
            32'd254: bus.mem_data_in = 32'h1234_5680;
            32'd255: bus.mem_data_in = 32'hFFFF_FF90;
            default: bus.mem_data_in = 32'hDEAD_BE00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit IDLE; returns at the negedge of the following IDLE cycle.
    task automatic exc_seq(input string tag, input logic op, input logic ov, input logic dv,
                           input logic rf, input logic [31:0] pc, input logic [1:0] c,
                           input logic [31:0] epc, input logic [31:0] tgt, input bit hold);
        bus.exc_opcode = op; bus.exc_overflow = ov; bus.exc_div0 = dv; bus.rfe = rf; bus.pc_in = pc;
        check({tag, " idle busy"}, 32'(bus.exc_busy), 32'd0);
        @(negedge clk);
        if (!hold) begin
            bus.exc_opcode = 1'b0; bus.exc_overflow = 1'b0; bus.exc_div0 = 1'b0;
        end
        bus.rfe   = 1'b0;
        bus.pc_in = pc ^ 32'h0000_1000;
        for (int i = 0; i < LAT; i++) begin
            check({tag, " mem_read"}, 32'(bus.mem_read), 32'd1);
            check({tag, " mem_addr"}, bus.mem_addr, 32'd253 + 32'(c));
            check({tag, " read pc_load"}, 32'(bus.pc_load), 32'd0);
            check({tag, " busy"}, 32'(bus.exc_busy), 32'd1);
            check({tag, " epc"}, bus.epc_out, epc);
            check({tag, " cause"}, 32'(bus.cause_out), 32'(c));
            @(negedge clk);
        end
        check({tag, " load pc_load"}, 32'(bus.pc_load), 32'd1);
        check({tag, " load target"}, bus.exc_target, tgt);
        check({tag, " load mem_read"}, 32'(bus.mem_read), 32'd0);
        check({tag, " load mem_addr"}, bus.mem_addr, 32'd0);
        @(negedge clk);
        check({tag, " end pc_load"}, 32'(bus.pc_load), 32'd0);
        check({tag, " end busy"}, 32'(bus.exc_busy), 32'd0);
        check({tag, " end target hold"}, bus.exc_target, tgt);
        check({tag, " end epc"}, bus.epc_out, epc);
    endtask

    task automatic rfe_seq(input string tag, input logic [31:0] tgt);
        bus.rfe = 1'b1;
        check({tag, " idle busy"}, 32'(bus.exc_busy), 32'd0);
        @(negedge clk);
        bus.rfe = 1'b0;
        check({tag, " pc_load"}, 32'(bus.pc_load), 32'd1);
        check({tag, " target"}, bus.exc_target, tgt);
        check({tag, " busy"}, 32'(bus.exc_busy), 32'd1);
        check({tag, " mem_read"}, 32'(bus.mem_read), 32'd0);
        @(negedge clk);
        check({tag, " end pc_load"}, 32'(bus.pc_load), 32'd0);
        check({tag, " end busy"}, 32'(bus.exc_busy), 32'd0);
        check({tag, " end target hold"}, bus.exc_target, tgt);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.exc_opcode = 1'b0; bus.exc_overflow = 1'b0; bus.exc_div0 = 1'b0;
        bus.rfe = 1'b0; bus.pc_in = 32'd0;
        repeat (2) @(negedge clk);
        check("rst pc_load", 32'(bus.pc_load), 32'd0);
        check("rst mem_read", 32'(bus.mem_read), 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst target", bus.exc_target, 32'd0);
        check("rst epc", bus.epc_out, 32'd0);
        check("rst cause", 32'(bus.cause_out), 32'd0);
        check("rst busy", 32'(bus.exc_busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        exc_seq("ovf", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 2'd1, 32'h0000_003C, 32'h0000_0080, 1'b0);
        rfe_seq("rfe", 32'h0000_003C);
        exc_seq("prio", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 2'd0, 32'h0000_00FC, 32'h0000_0020, 1'b0);
        exc_seq("rfe+div0", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 2'd2, 32'h0000_01FC, 32'h0000_0090, 1'b0);
        check("rfe dropped busy", 32'(bus.exc_busy), 32'd0);

        exc_seq("held1", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 2'd2, 32'h0000_02FC, 32'h0000_0090, 1'b1);
        exc_seq("held2", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 2'd2, 32'h0000_03FC, 32'h0000_0090, 1'b0);

        bus.exc_overflow = 1'b1; bus.pc_in = 32'h0000_0500;
        @(negedge clk);
        bus.exc_overflow = 1'b0;
        check("mid read", 32'(bus.mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst pc_load", 32'(bus.pc_load), 32'd0);
        check("midrst mem_read", 32'(bus.mem_read), 32'd0);
        check("midrst busy", 32'(bus.exc_busy), 32'd0);
        check("midrst epc", bus.epc_out, 32'd0);
        check("midrst target", bus.exc_target, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("postrst pc_load", 32'(bus.pc_load), 32'd0);
        check("postrst mem_read", 32'(bus.mem_read), 32'd0);

        exc_seq("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 32'hFFFF_FFFC, 32'h0000_0020, 1'b0);

`ifdef EXC_COUNT_EN
        check("cnt after wrap", 32'(exc_count), 32'd1);
        bus.exc_div0 = 1'b1;
        repeat (40) @(negedge clk);
        bus.exc_div0 = 1'b0;
        check("cnt 11 busy", 32'(bus.exc_busy), 32'd0);
        check("cnt 11", 32'(exc_count), 32'd11);
        bus.exc_div0 = 1'b1;
        repeat (300 * 4) @(negedge clk);
        bus.exc_div0 = 1'b0;
        repeat (4) @(negedge clk);
        check("cnt saturate", 32'(exc_count), 32'h0000_00FF);
        rfe_seq("cnt rfe", 32'hFFFF_FFFC ^ 32'h0 ^ bus.epc_out ^ 32'hFFFF_FFFC);
        check("cnt rfe no count", 32'(exc_count), 32'h0000_00FF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
